// File: rtl/cube_pkg.sv
// Shared definitions for the cube-root checker.
//   XW_DEF / RW_DEF : default operand and root widths
//   PW              : width of every product held in the multiplier datapath
//   MUL_CYC         : multiplier bits consumed per multiply (one per cycle)
//   state_t         : checker FSM states
package cube_pkg;

    localparam int XW_DEF  = 8;
    localparam int RW_DEF  = 3;
    localparam int PW      = 10;   // 8^3 = 512 is the largest value held
    localparam int MUL_CYC = 4;    // multiplier width == cycles per multiply

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO_SQ,
        MUL_LO_CB,
        MUL_HI_SQ,
        MUL_HI_CB,
        CMP,
        HOLD
    } state_t;

endpackage

// File: rtl/mul_shift_add.sv
// Sequential shift-add multiplier, one multiplier bit per cycle, LSB first.
//   clk, rst_n : clock, async active-low reset
//   i_start    : load operands (ignored while busy); the start edge already
//                consumes multiplier bit 0, so a multiply spans MUL_CYC edges
//   i_mcand    : PW-bit multiplicand
//   i_mplier   : MUL_CYC-bit multiplier
//   o_product  : accumulated product, final once o_done is high
//   o_busy     : multiply in progress
//   o_done     : one-cycle pulse after the last bit has been accumulated
module mul_shift_add
    import cube_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_start,
    input  logic [PW-1:0]      i_mcand,
    input  logic [MUL_CYC-1:0] i_mplier,
    output logic [PW-1:0]      o_product,
    output logic               o_busy,
    output logic               o_done
);

    localparam int CW = $clog2(MUL_CYC + 1);

    logic [PW-1:0]      r_mcand;
    logic [MUL_CYC-1:0] r_mplier;
    logic [PW-1:0]      r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (i_start && !r_busy) begin
            r_mcand  <= i_mcand << 1;
            r_mplier <= i_mplier >> 1;
            r_acc    <= i_mplier[0] ? i_mcand : '0;
            r_cnt    <= CW'(1);
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_busy) begin
            r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
            if (r_cnt == CW'(MUL_CYC - 1)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_product = r_acc;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule

// File: rtl/cube_root_checker.sv
// Checks a cube-root stage result: ok when root^3 <= x < (root+1)^3.
// One shared shift-add multiplier computes r*r, (r*r)*r, (r+1)*(r+1),
// ((r+1)^2)*(r+1) in turn; result is held until the consumer takes it.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   in_x, in_root       : operand and candidate floor cube root
//   out_valid/out_ready : result handshake (valid only in HOLD)
//   out_ok              : root is the floor cube root of x
//   out_cube            : root^3
//   err_cnt             : delivered results with out_ok=0, saturating
//   chk_cnt             : delivered results, wrapping
module cube_root_checker
    import cube_pkg::*;
#(
    parameter int XW = XW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] in_x,
    input  logic [RW-1:0] in_root,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_ok,
    output logic [PW-1:0] out_cube,
    output logic [7:0]    err_cnt,
    output logic [7:0]    chk_cnt
);

    state_t             r_state, w_next;
    logic [XW-1:0]      r_x;
    logic [RW-1:0]      r_root;
    logic [PW-1:0]      r_lo;
    logic               r_out_ok;
    logic [PW-1:0]      r_out_cube;
    logic [7:0]         r_err;
    logic [7:0]         r_chk;

    logic [RW:0]        w_r1;       // r+1 one bit wider so r=max does not wrap
    logic               w_start;
    logic [PW-1:0]      w_mcand;
    logic [MUL_CYC-1:0] w_mplier;
    logic [PW-1:0]      w_prod;
    logic               w_busy;
    logic               w_done;
    logic [PW-1:0]      w_x_ext;

    assign w_r1    = {1'b0, r_root} + (RW+1)'(1);
    assign w_x_ext = PW'(r_x);

    mul_shift_add u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_start),
        .i_mcand   (w_mcand),
        .i_mplier  (w_mplier),
        .o_product (w_prod),
        .o_busy    (w_busy),
        .o_done    (w_done)
    );

    // The first multiply launches in the first MUL_LO_SQ cycle (operands
    // were just registered); each later multiply launches in the done cycle
    // of the previous one, so its product feeds the next start directly.
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_mcand  = '0;
        w_mplier = '0;
        case (r_state)
            IDLE: begin
                if (in_valid) w_next = MUL_LO_SQ;
            end
            MUL_LO_SQ: begin
                if (w_done) begin
                    w_next   = MUL_LO_CB;
                    w_start  = 1'b1;
                    w_mcand  = w_prod;
                    w_mplier = MUL_CYC'(r_root);
                end else if (!w_busy) begin
                    w_start  = 1'b1;
                    w_mcand  = PW'(r_root);
                    w_mplier = MUL_CYC'(r_root);
                end
            end
            MUL_LO_CB: begin
                if (w_done) begin
                    w_next   = MUL_HI_SQ;
                    w_start  = 1'b1;
                    w_mcand  = PW'(w_r1);
                    w_mplier = MUL_CYC'(w_r1);
                end
            end
            MUL_HI_SQ: begin
                if (w_done) begin
                    w_next   = MUL_HI_CB;
                    w_start  = 1'b1;
                    w_mcand  = w_prod;
                    w_mplier = MUL_CYC'(w_r1);
                end
            end
            MUL_HI_CB: begin
                if (w_done) w_next = CMP;
            end
            CMP: begin
                w_next = HOLD;
            end
            HOLD: begin
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_x        <= '0;
            r_root     <= '0;
            r_lo       <= '0;
            r_out_ok   <= 1'b0;
            r_out_cube <= '0;
            r_err      <= '0;
            r_chk      <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && in_valid) begin
                r_x    <= in_x;
                r_root <= in_root;
            end
            if (r_state == MUL_LO_CB && w_done) r_lo <= w_prod;
            // Multiplier is idle in CMP, so its product still holds (r+1)^3.
            if (r_state == CMP) begin
                r_out_ok   <= (r_lo <= w_x_ext) && (w_x_ext < w_prod);
                r_out_cube <= r_lo;
            end
            if (r_state == HOLD && out_ready) begin
                r_chk <= r_chk + 8'd1;
                if (!r_out_ok && r_err != 8'hFF) r_err <= r_err + 8'd1;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign out_ok    = r_out_ok;
    assign out_cube  = r_out_cube;
    assign err_cnt   = r_err;
    assign chk_cnt   = r_chk;

endmodule

// File: tb/tb_cube_root_checker.sv
// Self-checking bench for cube_root_checker: vector table through a
// scoreboard, plus backpressure, mid-check reset and counter-limit sequences.
module tb_cube_root_checker;

    typedef struct {
        logic [7:0] x;
        logic [2:0] r;
        logic       ok;
        logic [9:0] cube;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [2:0] in_root;
    logic       out_valid;
    logic       out_ready;
    logic       out_ok;
    logic [9:0] out_cube;
    logic [7:0] err_cnt;
    logic [7:0] chk_cnt;

    cube_root_checker #(.XW(8), .RW(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_root   (in_root),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ok    (out_ok),
        .out_cube  (out_cube),
        .err_cnt   (err_cnt),
        .chk_cnt   (chk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   mdl_chk = 0;
    int   mdl_err = 0;
    vec_t cur_exp;
    vec_t mon_e;
    vec_t exp_q[$];
    int   acc_q[$];
    bit   prev_ov = 1'b0;
    vec_t tbl[12];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: samples 1 time unit after the falling edge, when
    // the bench has finished driving and the next rising edge decides.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                acc_q.push_back(cyc + 1);
            end
            if (out_valid && !prev_ov) begin
                if (acc_q.size() == 0) chk("unexpected_out_valid", 32'(acc_q.size()), 1);
                else                   chk("latency", 32'(cyc - acc_q[0]), 18);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'(exp_q.size()), 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    chk("out_ok", 32'(out_ok), 32'(mon_e.ok));
                    chk("out_cube", 32'(out_cube), 32'(mon_e.cube));
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input vec_t v);
        int n;
        n = 0;
        @(negedge clk);
        cur_exp  = v;
        in_x     = v.x;
        in_root  = v.r;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs: the checker must ignore them while busy.
        in_x     = 8'($urandom);
        in_root  = 3'($urandom);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            #2;
            n++;
        end while ((exp_q.size() != 0 || !in_ready) && n < 200);
        if (exp_q.size() != 0 || !in_ready) begin
            chk("done_timeout", 32'(exp_q.size()), 0);
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic model_count(input logic ok);
        mdl_chk = (mdl_chk + 1) & 255;
        if (!ok && mdl_err < 255) mdl_err++;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        mdl_chk = 0;
        mdl_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;

        tbl[0]  = '{8'd27,  3'd3, 1'b1, 10'd27};
        tbl[1]  = '{8'd255, 3'd6, 1'b1, 10'd216};
        tbl[2]  = '{8'd0,   3'd0, 1'b1, 10'd0};
        tbl[3]  = '{8'd255, 3'd7, 1'b0, 10'd343};
        tbl[4]  = '{8'd90,  3'd3, 1'b0, 10'd27};
        tbl[5]  = '{8'd63,  3'd3, 1'b1, 10'd27};
        tbl[6]  = '{8'd64,  3'd4, 1'b1, 10'd64};
        tbl[7]  = '{8'd26,  3'd3, 1'b0, 10'd27};
        tbl[8]  = '{8'd124, 3'd4, 1'b1, 10'd64};
        tbl[9]  = '{8'd125, 3'd5, 1'b1, 10'd125};
        tbl[10] = '{8'd7,   3'd1, 1'b1, 10'd1};
        tbl[11] = '{8'd8,   3'd1, 1'b0, 10'd1};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_root   = '0;
        out_ready = 1'b1;
        cur_exp   = '{8'd0, 3'd0, 1'b0, 10'd0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_ok", 32'(out_ok), 0);
        chk("rst_out_cube", 32'(out_cube), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_chk_cnt", 32'(chk_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table, consumer always ready
        for (int i = 0; i < 12; i++) begin
            send(tbl[i]);
            wait_done();
            model_count(tbl[i].ok);
            chk("tbl_chk_cnt", 32'(chk_cnt), 32'(mdl_chk));
            chk("tbl_err_cnt", 32'(err_cnt), 32'(mdl_err));
        end

        // Backpressure in HOLD
        @(negedge clk);
        out_ready = 1'b0;
        v = '{8'd27, 3'd3, 1'b1, 10'd27};
        send(v);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("bp_out_valid", 32'(out_valid), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_x     = 8'd200;
            in_root  = 3'd5;
            cur_exp  = '{8'd200, 3'd5, 1'b1, 10'd125};
            #2;
            chk("bp_hold_valid", 32'(out_valid), 1);
            chk("bp_hold_ok", 32'(out_ok), 1);
            chk("bp_hold_cube", 32'(out_cube), 27);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("bp_no_passthru", 32'(in_ready), 0);
        @(negedge clk);
        #2;
        chk("bp_ready_after", 32'(in_ready), 1);
        chk("bp_queue_empty", 32'(exp_q.size()), 0);
        model_count(1'b1);
        chk("bp_chk_cnt", 32'(chk_cnt), 32'(mdl_chk));
        repeat (25) @(negedge clk);
        #2;
        chk("bp_no_extra_out", 32'(out_valid), 0);

        // Reset in the middle of a check
        v = '{8'd100, 3'd4, 1'b1, 10'd64};
        send(v);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_in_ready", 32'(in_ready), 1);
        chk("mid_out_valid", 32'(out_valid), 0);
        chk("mid_out_ok", 32'(out_ok), 0);
        chk("mid_out_cube", 32'(out_cube), 0);
        chk("mid_err_cnt", 32'(err_cnt), 0);
        chk("mid_chk_cnt", 32'(chk_cnt), 0);
        exp_q.delete();
        acc_q.delete();
        mdl_chk = 0;
        mdl_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        v = '{8'd27, 3'd3, 1'b1, 10'd27};
        send(v);
        wait_done();
        model_count(1'b1);
        chk("mid_after_chk", 32'(chk_cnt), 32'(mdl_chk));
        chk("mid_after_err", 32'(err_cnt), 32'(mdl_err));

        // Counter limits: 256 failing checks
        pulse_reset();
        v = '{8'd255, 3'd7, 1'b0, 10'd343};
        for (int i = 0; i < 256; i++) begin
            send(v);
            wait_done();
            model_count(1'b0);
            if (i == 254) begin
                chk("lim_err_255", 32'(err_cnt), 255);
                chk("lim_chk_255", 32'(chk_cnt), 255);
            end
        end
        chk("lim_err_sat", 32'(err_cnt), 32'(mdl_err));
        chk("lim_chk_wrap", 32'(chk_cnt), 32'(mdl_chk));
        chk("lim_err_const", 32'(err_cnt), 255);
        chk("lim_chk_zero", 32'(chk_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cube_root_checker.md
CUBE_ROOT_CHECKER -- requirements
Module: cube_root_checker

Interface
REQ-001 Parameter XW, default 8: operand width; the cube-root stage input is 0..255.
REQ-002 Parameter RW, default 3: root width; covers every floor cube root of an XW-bit operand.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 in_valid  input  1: operand/root pair is valid.
REQ-006 in_ready  output  1: checker accepts a pair; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-007 in_x  input  XW: operand given to the cube-root stage.
REQ-008 in_root  input  RW: root produced by the cube-root stage.
REQ-009 out_valid  output  1: check result is valid.
REQ-010 out_ready  input  1: consumer accepts the result.
REQ-011 out_ok  output  1: high when in_root^3 <= in_x < (in_root+1)^3.
REQ-012 out_cube  output  10: in_root^3, zero-extended.
REQ-013 err_cnt  output  8: count of results delivered with out_ok=0; saturates at 255.
REQ-014 chk_cnt  output  8: count of results delivered; wraps from 255 to 0.

Function
REQ-015 FSM states SHALL be IDLE, MUL_LO_SQ, MUL_LO_CB, MUL_HI_SQ, MUL_HI_CB, CMP and HOLD.
REQ-016 in_ready SHALL be high only in IDLE.
REQ-017 On the in_valid handshake, in_x and in_root SHALL be registered, and the FSM SHALL move to MUL_LO_SQ.
REQ-018 Each MUL_* state SHALL run one 4-cycle shift-add multiply, consuming one multiplier bit per cycle, LSB first; it SHALL then advance.
REQ-019 The multiplies SHALL be, in order: s=r*r, lo=s*r, t=(r+1)*(r+1), hi=t*(r+1).
REQ-020 The value r+1 SHALL be formed in RW+1 bits, so r=7 gives 8 with no wrap.
REQ-021 All products SHALL be held in 10 bits; the largest value, 8^3=512, fits without overflow.
REQ-022 CMP SHALL take 1 cycle, set out_ok=(lo<=x)&&(x<hi) and out_cube=lo, and then move to HOLD.
REQ-023 out_valid SHALL be high exactly in HOLD; it SHALL rise 18 rising edges after the input handshake edge.
REQ-024 In HOLD, out_ok and out_cube SHALL remain stable until out_ready is high.
REQ-025 When out_valid and out_ready are both high, the FSM SHALL return to IDLE; in_ready SHALL rise on the next cycle, giving no same-cycle pass-through.
REQ-026 On each output handshake, chk_cnt SHALL increment by 1, and err_cnt SHALL increment only if out_ok=0 and err_cnt<255.
REQ-027 Input changes outside IDLE SHALL be ignored.

Reset
REQ-028 While rst_n is low, the FSM SHALL be in IDLE and in_ready SHALL be 1.
REQ-029 While rst_n is low, out_valid, out_ok, out_cube, err_cnt and chk_cnt SHALL be 0.
REQ-030 While rst_n is low, the multiplier datapath registers SHALL be 0.
REQ-031 Reset asserted mid-check SHALL abort the check with no output handshake and no counter update.
REQ-032 Reset SHALL assert asynchronously; release SHALL take effect at the next rising clk edge.

Structure
REQ-033 A shared package cube_pkg SHALL hold the FSM state enum, XW/RW defaults, the product width (10) and the multiply cycle count (4).
REQ-034 A single sub-module, mul_shift_add, SHALL perform the 4-cycle sequential multiply.
REQ-035 mul_shift_add SHALL take a 10-bit multiplicand, a 4-bit multiplier and start, and SHALL produce a 10-bit product with done.
REQ-036 All four multiplies SHALL reuse the one mul_shift_add instance.

Verification
REQ-037 Pass case: x=27, r=3 with out_ready=1 -> out_valid at edge 18 after acceptance, out_ok=1, out_cube=27, chk_cnt=1, err_cnt=0.
REQ-038 Boundary passes: x=255, r=6 -> out_ok=1, out_cube=216; x=0, r=0 -> out_ok=1, out_cube=0.
REQ-039 Top-root failures: x=255, r=7 -> out_ok=0, out_cube=343, err_cnt=1; x=90, r=3 -> out_ok=0, since 90>=64.
REQ-040 Backpressure: out_ready=0 for 10 cycles in HOLD -> outputs stable, in_ready=0, and a new in_valid is not accepted; in_ready=1 one cycle after out_ready rises.
REQ-041 Mid-check reset: rst_n pulsed low at cycle 7 of a check -> all outputs return to reset values immediately, and the next check completes normally.
REQ-042 Counter limits: 256 forced failures -> err_cnt holds 255 and chk_cnt wraps to 0.
